// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among NUM_REQ requesters.
// One operation in flight; compares wait an extra cycle for the ALU flag register.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned NUM_REQ      = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_op_b,
    input  logic [NUM_REQ*OPCODE_WIDTH-1:0]  req_opcode,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_result,
    output logic                             rsp_equal,
    output logic                             rsp_less,
    output logic                             rsp_greater,
    output logic [DATA_WIDTH-1:0]            alu_op_a,
    output logic [DATA_WIDTH-1:0]            alu_op_b,
    output logic [OPCODE_WIDTH-1:0]          alu_opcode,
    output logic                             alu_active,
    input  logic [DATA_WIDTH-1:0]            alu_result,
    input  logic                             alu_equal,
    input  logic                             alu_less,
    input  logic                             alu_greater
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] FLAG = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [OPCODE_WIDTH-1:0] OP_CMP = OPCODE_WIDTH'(4'b1000);

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [2:0]              flags_q, flags_d;  // {equal, less, greater}

    logic                    gnt_found;
    logic [IDX_W-1:0]        gnt_idx;
    logic [DATA_WIDTH-1:0]   gnt_a, gnt_b;
    logic [OPCODE_WIDTH-1:0] gnt_op;

    // First valid requester at or after ptr, wrapping; operands picked alongside.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        gnt_op    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[k] &&
                ((32'(ptr_q) <= k) ||
                 !(|(req_valid & ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1)))))) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(k);
                gnt_a     = req_op_a[k*DATA_WIDTH +: DATA_WIDTH];
                gnt_b     = req_op_b[k*DATA_WIDTH +: DATA_WIDTH];
                gnt_op    = req_opcode[k*OPCODE_WIDTH +: OPCODE_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    op_a_d   = gnt_a;
                    op_b_d   = gnt_b;
                    opcode_d = gnt_op;
                    owner_d  = gnt_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (opcode_q == OP_CMP) begin
                    state_d = FLAG;
                end else begin
                    result_d = alu_result;
                    flags_d  = {alu_equal, alu_less, alu_greater};
                    state_d  = RESP;
                end
            end
            FLAG: begin
                result_d = alu_result;
                flags_d  = {alu_equal, alu_less, alu_greater};
                state_d  = RESP;
            end
            default: begin
                if (rsp_ready[owner_q]) begin
                    ptr_d   = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign req_ready   = (state_q == IDLE && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign rsp_valid   = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_result  = result_q;
    assign rsp_equal   = flags_q[2];
    assign rsp_less    = flags_q[1];
    assign rsp_greater = flags_q[0];
    assign alu_op_a    = op_a_q;
    assign alu_op_b    = op_b_q;
    assign alu_opcode  = opcode_q;
    // Only arbitrated compares may touch the ALU flag register.
    assign alu_active  = (state_q == EXEC) && (opcode_q == OP_CMP);

endmodule
